// File: rtl/edge_wait_checker.sv
// Protocol monitor: measures enable-rise to trigger-rise latency and flags mismatches/timeouts.
// Define EDGE_WAIT_CHECKER_SYNC_EN to pass enable/trigger through 2-flop synchronizers first.
module edge_wait_checker #(
    parameter int CW              = 8,
    parameter int EXPECTED_CYCLES = 5,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int ERRW            = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            trigger,
    output logic            done,
    output logic [CW-1:0]   latency,
    output logic            match,
    output logic            timeout,
    output logic            retrig,
    output logic            busy,
    output logic [ERRW-1:0] err_count
);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    localparam logic [CW-1:0]   EXP_C   = CW'(EXPECTED_CYCLES);
    localparam logic [CW-1:0]   TO_C    = CW'(TIMEOUT_CYCLES);
    localparam logic [ERRW-1:0] ERR_MAX = '1;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next, cnt_inc;
    logic [CW-1:0]   latency_next;
    logic            match_next, done_next, timeout_next, retrig_next;
    logic            err_inc;
    logic [ERRW-1:0] err_next;
    logic            en_in, trg_in, en_q, trg_q, en_rise, trg_rise;

`ifdef EDGE_WAIT_CHECKER_SYNC_EN
    logic [1:0] en_sync, trg_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sync  <= '0;
            trg_sync <= '0;
        end else begin
            en_sync  <= {en_sync[0], enable};
            trg_sync <= {trg_sync[0], trigger};
        end
    end

    assign en_in  = en_sync[1];
    assign trg_in = trg_sync[1];
`else
    assign en_in  = enable;
    assign trg_in = trigger;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            trg_q <= 1'b0;
        end else begin
            en_q  <= en_in;
            trg_q <= trg_in;
        end
    end

    assign en_rise  = en_in & ~en_q;
    assign trg_rise = trg_in & ~trg_q;
    assign cnt_inc  = cnt + CW'(1);

    // A fresh enable edge always restarts the measurement, even if trigger rose in the same cycle.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        latency_next = latency;
        match_next   = match;
        done_next    = 1'b0;
        timeout_next = 1'b0;
        retrig_next  = 1'b0;
        err_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (en_rise) begin
                    state_next = COUNT;
                    cnt_next   = '0;
                end
            end
            COUNT: begin
                if (en_rise) begin
                    cnt_next    = '0;
                    retrig_next = 1'b1;
                end else if (trg_rise) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    latency_next = cnt_inc;
                    match_next   = (cnt_inc == EXP_C);
                    done_next    = 1'b1;
                    err_inc      = (cnt_inc != EXP_C);
                end else if (cnt_inc == TO_C) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                    err_inc      = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
        endcase
    end

    assign err_next = (err_inc && (err_count != ERR_MAX)) ? err_count + ERRW'(1) : err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            latency   <= '0;
            match     <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            retrig    <= 1'b0;
            busy      <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            latency   <= latency_next;
            match     <= match_next;
            done      <= done_next;
            timeout   <= timeout_next;
            retrig    <= retrig_next;
            busy      <= (state_next == COUNT);
            err_count <= err_next;
        end
    end

endmodule

// File: tb/tb_edge_wait_checker.sv
// Directed bench for edge_wait_checker; pulses are checked against a scoreboard of expected events.
module tb_edge_wait_checker;

    localparam int CW      = 8;
    localparam int EXP     = 5;
    localparam int TO      = 16;
    localparam int ERRW    = 2;
    localparam int ERR_MAX = (1 << ERRW) - 1;
`ifdef EDGE_WAIT_CHECKER_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    // kind is the one-hot {retrig, timeout, done} pattern expected at cycle
    typedef struct {
        int kind;
        int cycle;
        int lat;
        int mat;
        int err;
        int bsy;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic            trigger;
    logic            done;
    logic [CW-1:0]   latency;
    logic            match;
    logic            timeout;
    logic            retrig;
    logic            busy;
    logic [ERRW-1:0] err_count;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   exp_err = 0;
    int   last_lat = 0;
    int   last_match = 0;
    exp_t sbq[$];
    exp_t mon_item;

    edge_wait_checker #(
        .CW(CW),
        .EXPECTED_CYCLES(EXP),
        .TIMEOUT_CYCLES(TO),
        .ERRW(ERRW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .trigger(trigger),
        .done(done),
        .latency(latency),
        .match(match),
        .timeout(timeout),
        .retrig(retrig),
        .busy(busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic to_cycle(input int n);
        while (cyc < n) step();
    endtask

    function automatic int sat_inc(input int v);
        return (v < ERR_MAX) ? v + 1 : v;
    endfunction

    task automatic push_done(input int e_edge, input int lat);
        int m;
        m = (lat == EXP) ? 1 : 0;
        if (m == 0) exp_err = sat_inc(exp_err);
        last_lat   = lat;
        last_match = m;
        sbq.push_back('{1, e_edge + lat + SD, lat, m, exp_err, 0});
    endtask

    task automatic push_timeout(input int e_edge);
        exp_err = sat_inc(exp_err);
        sbq.push_back('{2, e_edge + TO + SD, last_lat, last_match, exp_err, 0});
    endtask

    task automatic push_retrig(input int e_edge);
        sbq.push_back('{4, e_edge + SD, last_lat, last_match, exp_err, 1});
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            step();
            n++;
        end
        tests++;
        assert (sbq.size() == 0)
        else begin
            fails++;
            $error("[TB] FAIL drain_timeout: observed %0d pending events, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic apply_pair(input int lat);
        push_done(cyc + 1, lat);
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (lat - 1) step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        drain(40);
        repeat (3) step();
    endtask

    // Every pulse must match the oldest outstanding expectation in kind, timing and held outputs.
    always @(negedge clk) begin
        if (done | timeout | retrig) begin
            tests++;
            assert (sbq.size() > 0)
            else begin
                fails++;
                $error("[TB] FAIL unexpected_pulse: observed kind %0d at cycle %0d, expected none",
                       {retrig, timeout, done}, cyc);
            end
            if (sbq.size() > 0) begin
                mon_item = sbq.pop_front();
                check_output("pulse_kind", 32'({retrig, timeout, done}), mon_item.kind);
                check_output("pulse_cycle", cyc, mon_item.cycle);
                check_output("latency", 32'(latency), mon_item.lat);
                check_output("match", 32'(match), mon_item.mat);
                check_output("err_count", 32'(err_count), mon_item.err);
                check_output("busy_at_pulse", 32'(busy), mon_item.bsy);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e;
        int busy_cnt;

        rst_n   = 1'b0;
        enable  = 1'b0;
        trigger = 1'b0;
        repeat (3) step();
        check_output("rst_done", 32'(done), 0);
        check_output("rst_latency", 32'(latency), 0);
        check_output("rst_match", 32'(match), 0);
        check_output("rst_timeout", 32'(timeout), 0);
        check_output("rst_retrig", 32'(retrig), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_err_count", 32'(err_count), 0);
        rst_n = 1'b1;
        to_cycle(9);

        // Matching latency, also counting how long busy stays high
        e = cyc + 1;
        push_done(e, 5);
        enable   = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            busy_cnt += int'(busy);
            if (i == 0) enable = 1'b0;
            if (i == 4) trigger = 1'b1;
            if (i == 5) trigger = 1'b0;
        end
        check_output("busy_cycles", busy_cnt, 5);
        drain(40);
        repeat (3) step();

        apply_pair(3);

        // Trigger never rises: timeout keeps the previous latency/match
        push_timeout(cyc + 1);
        enable = 1'b1;
        step();
        enable = 1'b0;
        drain(40);
        check_output("busy_after_timeout", 32'(busy), 0);
        repeat (3) step();

        // Second enable edge two cycles in restarts the count
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        enable = 1'b1;
        e = cyc + 1;
        push_retrig(e);
        push_done(e, 5);
        step();
        enable = 1'b0;
        to_cycle(e + 4);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        drain(40);
        repeat (3) step();

        // Trigger already high when enable rises gives no edge, so it times out
        trigger = 1'b1;
        repeat (5) step();
        push_timeout(cyc + 1);
        enable = 1'b1;
        step();
        enable = 1'b0;
        drain(40);
        trigger = 1'b0;
        repeat (4) step();

        // Reset in the middle of a measurement drops it
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (3 + SD) step();
        rst_n = 1'b0;
        #1;
        exp_err    = 0;
        last_lat   = 0;
        last_match = 0;
        check_output("midrst_busy", 32'(busy), 0);
        check_output("midrst_latency", 32'(latency), 0);
        check_output("midrst_err_count", 32'(err_count), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        trigger = 1'b1;
        repeat (8) step();
        trigger = 1'b0;
        check_output("postrst_busy", 32'(busy), 0);
        check_output("postrst_latency", 32'(latency), 0);
        check_output("postrst_match", 32'(match), 0);
        repeat (3) step();

        apply_pair(5);

        // Repeated mismatches drive the error counter into saturation
        for (int k = 0; k < 7; k++) apply_pair(3);
        check_output("err_saturated", 32'(err_count), ERR_MAX);

        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
